// File: rtl/sobel_edge_param.sv
// Streaming 3x3 Sobel edge detector with two line buffers.
// Fixed 4-cycle pipeline: window -> partial sums -> abs differences -> magnitude/output.
// Pixel strobe: a pixel is taken on a rising clk edge when per_frame_href and
// per_frame_clken are both high. There is no back-pressure. Every accepted pixel
// leaves as one output beat exactly 4 cycles later, marked by post_frame_clken.
module sobel_edge_param #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_Y,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W+2:0] cfg_threshold,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [DATA_W-1:0] post_img_data,
  output logic              post_edge_bit,
  output logic              line_ovf
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int SW = DATA_W + 2;
  localparam int MW = DATA_W + 3;

  // Input framing and counters
  logic              vsync_q, href_q, line_px;
  logic [CNT_W-1:0]  col_cnt, row_cnt;
  logic [1:0]        mode_sh;
  logic [MW-1:0]     thr_sh;

  logic              vs_rise, href_fall, accept, in_range, border0;
  logic [CNT_W-1:0]  col_cur, row_cur;
  logic [AW-1:0]     addr;

  // A pixel that arrives together with the vsync rise is (row 0, col 0) of the new frame.
  assign vs_rise   = per_frame_vsync & ~vsync_q;
  assign href_fall = ~per_frame_href & href_q;
  assign accept    = per_frame_href & per_frame_clken;
  assign col_cur   = vs_rise ? '0 : col_cnt;
  assign row_cur   = vs_rise ? '0 : row_cnt;
  assign in_range  = (col_cur < CNT_W'(IMG_W));
  assign border0   = (row_cur < CNT_W'(2)) || (col_cur < CNT_W'(2)) || !in_range;
  assign addr      = col_cur[AW-1:0];

  // Line buffers: lb1 holds line r-1, lb0 holds line r-2 (no reset; border masks stale data)
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb_top, lb_mid;

  assign lb_top = lb0[addr];
  assign lb_mid = lb1[addr];

  // Shift the column through the two line buffers on every in-range accepted pixel
  always_ff @(posedge clk) begin
    if (accept && in_range) begin
      lb0[addr] <= lb_mid;
      lb1[addr] <= per_img_Y;
    end
  end

  // Edge detectors, column/row counters, shadow config and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q  <= 1'b0;
      href_q   <= 1'b0;
      line_px  <= 1'b0;
      col_cnt  <= '0;
      row_cnt  <= '0;
      mode_sh  <= '0;
      thr_sh   <= '0;
      line_ovf <= 1'b0;
    end else begin
      vsync_q <= per_frame_vsync;
      href_q  <= per_frame_href;
      if (vs_rise) begin
        mode_sh  <= cfg_mode;
        thr_sh   <= cfg_threshold;
        line_ovf <= 1'b0;
      end else if (accept && !in_range) begin
        line_ovf <= 1'b1;
      end
      if (accept) begin
        col_cnt <= (col_cur == '1) ? col_cur : col_cur + CNT_W'(1);
      end else if (href_fall || vs_rise) begin
        col_cnt <= '0;
      end
      if (vs_rise) begin
        row_cnt <= '0;
      end else if (href_fall && line_px && (row_cnt != '1)) begin
        row_cnt <= row_cnt + CNT_W'(1);
      end
      if (accept) begin
        line_px <= 1'b1;
      end else if (href_fall) begin
        line_px <= 1'b0;
      end
    end
  end

  // Stage 1: 3x3 window (p11 top-left .. p33 bottom-right) plus per-beat tags
  logic [DATA_W-1:0] w11, w12, w13, w21, w22, w23, w31, w32, w33;
  logic              s1_acc, s1_border;

  // Window shifts only on accepted in-range pixels; tags advance every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {w11, w12, w13, w21, w22, w23, w31, w32, w33} <= '0;
      s1_acc    <= 1'b0;
      s1_border <= 1'b0;
    end else begin
      s1_acc    <= accept;
      s1_border <= border0;
      if (accept && in_range) begin
        w11 <= w12; w12 <= w13; w13 <= lb_top;
        w21 <= w22; w22 <= w23; w23 <= lb_mid;
        w31 <= w32; w32 <= w33; w33 <= per_img_Y;
      end
    end
  end

  // Stage 2: weighted column/row sums
  logic [SW-1:0]     s2_xp, s2_xn, s2_yp, s2_yn;
  logic [DATA_W-1:0] s2_p22;
  logic              s2_acc, s2_border;

  // Register the four 1-2-1 weighted sums of the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_xp <= '0; s2_xn <= '0; s2_yp <= '0; s2_yn <= '0;
      s2_p22 <= '0; s2_acc <= 1'b0; s2_border <= 1'b0;
    end else begin
      s2_xp     <= SW'(w13) + (SW'(w23) << 1) + SW'(w33);
      s2_xn     <= SW'(w11) + (SW'(w21) << 1) + SW'(w31);
      s2_yp     <= SW'(w11) + (SW'(w12) << 1) + SW'(w13);
      s2_yn     <= SW'(w31) + (SW'(w32) << 1) + SW'(w33);
      s2_p22    <= w22;
      s2_acc    <= s1_acc;
      s2_border <= s1_border;
    end
  end

  // Stage 3: absolute gradients
  logic [SW-1:0]     s3_gx, s3_gy;
  logic [DATA_W-1:0] s3_p22;
  logic              s3_acc, s3_border;

  // Register |Gx| and |Gy| as unsigned absolute differences
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_gx <= '0; s3_gy <= '0; s3_p22 <= '0; s3_acc <= 1'b0; s3_border <= 1'b0;
    end else begin
      s3_gx     <= (s2_xp >= s2_xn) ? (s2_xp - s2_xn) : (s2_xn - s2_xp);
      s3_gy     <= (s2_yp >= s2_yn) ? (s2_yp - s2_yn) : (s2_yn - s2_yp);
      s3_p22    <= s2_p22;
      s3_acc    <= s2_acc;
      s3_border <= s2_border;
    end
  end

  // Stage 4: magnitude, threshold compare and mode select
  logic [MW-1:0]     mag;
  logic [DATA_W-1:0] sat, data_c;
  logic              edge_c;

  // Border and overflow beats force the magnitude and edge to zero; idle beats output zero
  always_comb begin
    mag = MW'(s3_gx) + MW'(s3_gy);
    if (s3_border) mag = '0;
    edge_c = !s3_border && (mag >= thr_sh);
    sat = (mag > MW'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
    case (mode_sh)
      2'd1:    data_c = sat;
      2'd2:    data_c = s3_p22;
      default: data_c = edge_c ? {DATA_W{1'b1}} : '0;
    endcase
    if (!s3_acc) begin
      data_c = '0;
      edge_c = 1'b0;
    end
  end

  // Output data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_img_data <= '0;
      post_edge_bit <= 1'b0;
    end else begin
      post_img_data <= data_c;
      post_edge_bit <= edge_c;
    end
  end

  // Sync signals ride a plain 4-deep delay line alongside the data stages
  logic [2:0] sb1, sb2, sb3, sb4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb1 <= '0; sb2 <= '0; sb3 <= '0; sb4 <= '0;
    end else begin
      sb1 <= {per_frame_vsync, per_frame_href, per_frame_clken};
      sb2 <= sb1;
      sb3 <= sb2;
      sb4 <= sb3;
    end
  end

  assign post_frame_vsync = sb4[2];
  assign post_frame_href  = sb4[1];
  assign post_frame_clken = sb4[0];

endmodule

// File: tb/tb_sobel_edge_param.sv
// Directed bench for sobel_edge_param with IMG_W=16 and 8-row frames.
module tb_sobel_edge_param;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 16;
  localparam int CNT_W  = 12;
  localparam int ROWS   = 8;
  localparam int NVEC   = 15;

  // Clock / reset block
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0, href = 1'b0, clken = 1'b0;
  logic [7:0]  y = '0;
  logic [1:0]  mode = '0;
  logic [10:0] thr = '0;
  logic        post_vsync, post_href, post_clken, post_edge_bit, line_ovf;
  logic [7:0]  post_img_data;

  always #5 clk = ~clk;

  sobel_edge_param #(.DATA_W(DATA_W), .IMG_W(IMG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .per_img_Y(y), .cfg_mode(mode), .cfg_threshold(thr),
    .post_frame_vsync(post_vsync), .post_frame_href(post_href),
    .post_frame_clken(post_clken), .post_img_data(post_img_data),
    .post_edge_bit(post_edge_bit), .line_ovf(line_ovf)
  );

  // Frame vector: image is a vertical step (lo for col < step, hi otherwise);
  // expected outputs for the two step columns and for flat columns are hand-computed.
  typedef struct {
    logic [1:0]  mode;
    logic [10:0] thr;
    logic [7:0]  lo;
    logic [7:0]  hi;
    int          step;
    logic [7:0]  d_step;
    logic        e_step;
    logic [7:0]  d_flat;
    logic        e_flat;
    bit          gap;
    bit          vs_px;
    int          long_row;
    int          thr2;
  } vec_t;

  vec_t vecs [NVEC];

  // Scoreboard: {check, edge, data}
  logic [9:0] exp_q [$];
  int         total = 0;
  int         bad = 0;
  logic [2:0] hist [4];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] img(input vec_t v, input int c);
    if (c >= IMG_W) return v.lo;
    return (c < v.step) ? v.lo : v.hi;
  endfunction

  function automatic logic [9:0] expect_px(input vec_t v, input int r, input int c);
    logic       chk;
    logic       e;
    logic [7:0] d;
    chk = 1'b1;
    if (r < 2 || c < 2 || c >= IMG_W) begin
      e = 1'b0; d = '0;
    end else if (c == v.step || c == v.step + 1) begin
      e = v.e_step; d = v.d_step;
    end else begin
      e = v.e_flat; d = v.d_flat;
    end
    if (v.mode == 2'd2) begin
      chk = (r >= 1 && c >= 1 && c < IMG_W);
      d = chk ? img(v, c - 1) : 8'd0;
    end
    return {chk, e, d};
  endfunction

  // Input history for the 4-cycle sideband delay check
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hist[i] <= '0;
    end else begin
      hist[0] <= {vsync, href, clken};
      for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
    end
  end

  // Output monitor on the falling edge
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n) begin
      check("sideband_delay", {post_vsync, post_href, post_clken}, hist[3]);
      if (!post_href) check("idle_zero", {post_edge_bit, post_img_data}, 0);
      if (post_href && post_clken) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("edge_bit", post_edge_bit, e[8]);
          if (e[9]) check("img_data", post_img_data, e[7:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      href = 1'b0; clken = 1'b0; y = '0;
    end
  endtask

  task automatic vsync_pulse();
    @(negedge clk); vsync = 1'b1; href = 1'b0; clken = 1'b0;
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
    idle(2);
  endtask

  task automatic send_line(input vec_t v, input int r, input int ncols, input logic vs);
    for (int i = 0; i < ncols; i++) begin
      if (v.gap && (i % 3 == 1)) begin
        @(negedge clk); vsync = vs; href = 1'b1; clken = 1'b0; y = 8'hA5;
      end
      if (v.gap && i == 5) begin
        repeat (2) begin
          @(negedge clk); vsync = vs; href = 1'b1; clken = 1'b0; y = 8'h5A;
        end
      end
      @(negedge clk); vsync = vs; href = 1'b1; clken = 1'b1; y = img(v, i);
      exp_q.push_back(expect_px(v, r, i));
    end
    @(negedge clk); vsync = 1'b0; href = 1'b0; clken = 1'b0; y = '0;
    idle(3);
  endtask

  task automatic send_frame(input vec_t v);
    int n;
    mode = v.mode;
    thr  = v.thr;
    if (!v.vs_px) begin
      vsync_pulse();
      check("ovf_cleared_by_vsync", line_ovf, 0);
    end else begin
      idle(2);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (v.thr2 >= 0 && r == 4) thr = 11'(v.thr2);
      n = (r == v.long_row) ? IMG_W + 4 : IMG_W;
      send_line(v, r, n, v.vs_px && r == 0);
      check("line_ovf", line_ovf, (v.long_row >= 0 && r >= v.long_row) ? 1 : 0);
    end
  endtask

  initial begin
    vec_t rv;
    // mode thr lo hi step d_step e_step d_flat e_flat gap vs_px long_row thr2
    vecs[0]  = '{2'd1, 11'd250,  8'd100, 8'd100, 4, 8'd0,   1'b0, 8'd0,   1'b0, 1'b0, 1'b0, -1, -1};
    vecs[1]  = '{2'd1, 11'd250,  8'd0,   8'd200, 4, 8'd255, 1'b1, 8'd0,   1'b0, 1'b1, 1'b0, -1, -1};
    vecs[2]  = '{2'd0, 11'd250,  8'd0,   8'd200, 4, 8'd255, 1'b1, 8'd0,   1'b0, 1'b0, 1'b1, -1, -1};
    vecs[3]  = '{2'd0, 11'd800,  8'd0,   8'd200, 4, 8'd255, 1'b1, 8'd0,   1'b0, 1'b0, 1'b0, -1, -1};
    vecs[4]  = '{2'd0, 11'd801,  8'd0,   8'd200, 4, 8'd0,   1'b0, 8'd0,   1'b0, 1'b0, 1'b0, -1, -1};
    vecs[5]  = '{2'd1, 11'd100,  8'd10,  8'd50,  7, 8'd160, 1'b1, 8'd0,   1'b0, 1'b1, 1'b0, -1, -1};
    vecs[6]  = '{2'd1, 11'd161,  8'd50,  8'd10,  7, 8'd160, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, -1, -1};
    vecs[7]  = '{2'd3, 11'd250,  8'd0,   8'd200, 4, 8'd255, 1'b1, 8'd0,   1'b0, 1'b0, 1'b0, -1, -1};
    vecs[8]  = '{2'd2, 11'd250,  8'd0,   8'd200, 4, 8'd0,   1'b1, 8'd0,   1'b0, 1'b0, 1'b0, -1, -1};
    vecs[9]  = '{2'd0, 11'd0,    8'd100, 8'd100, 4, 8'd255, 1'b1, 8'd255, 1'b1, 1'b0, 1'b0, -1, -1};
    vecs[10] = '{2'd1, 11'd2047, 8'd0,   8'd255, 4, 8'd255, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, -1, -1};
    vecs[11] = '{2'd1, 11'd250,  8'd0,   8'd200, 4, 8'd255, 1'b1, 8'd0,   1'b0, 1'b0, 1'b0, -1, 900};
    vecs[12] = '{2'd1, 11'd900,  8'd0,   8'd200, 4, 8'd255, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, -1, -1};
    vecs[13] = '{2'd1, 11'd250,  8'd0,   8'd200, 4, 8'd255, 1'b1, 8'd0,   1'b0, 1'b0, 1'b0, 3,  -1};
    vecs[14] = '{2'd0, 11'd250,  8'd0,   8'd200, 9, 8'd255, 1'b1, 8'd0,   1'b0, 1'b0, 1'b0, -1, -1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {post_vsync, post_href, post_clken, post_img_data, post_edge_bit, line_ovf}, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) send_frame(vecs[i]);
    idle(8);
    check("queue_drained", exp_q.size(), 0);

    // Reset in the middle of row 3 of a step frame
    rv = vecs[2];
    rv.vs_px = 1'b0;
    mode = rv.mode; thr = rv.thr;
    vsync_pulse();
    for (int r = 0; r < 3; r++) send_line(rv, r, IMG_W, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); href = 1'b1; clken = 1'b1; y = img(rv, i);
      exp_q.push_back(expect_px(rv, 3, i));
    end
    @(posedge clk); #1;
    check("pre_reset_href_active", post_href, 1);
    #1 rst_n = 1'b0;
    href = 1'b0; clken = 1'b0; y = '0;
    #1;
    check("reset_async_outputs", {post_vsync, post_href, post_clken, post_img_data, post_edge_bit, line_ovf}, 0);
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1;
    check("reset_held_outputs", {post_vsync, post_href, post_clken, post_img_data, post_edge_bit}, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Next frame: black image, stale step lines in the buffers must not produce edges
    rv = '{2'd0, 11'd250, 8'd0, 8'd0, 4, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, -1, -1};
    send_frame(rv);
    send_frame(vecs[1]);
    idle(8);
    check("queue_drained_after_reset", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
